fir_sample_source: RTL
======================

Name: fir_sample_source

Overview:
Synthesizable stimulus transmitter for the FIR filter input interface (DOUT/VOUT sample stream plus H0..H6 coefficient bus). Once started, it emits a programmable number of NB-bit signed samples with a programmable idle gap between valid samples. After a drain window it raises a sticky END_SIM flag. It sits on the producer side of the FIR in on-chip self-test wrappers and benches, in place of a file-driven sample source.

Parameters:
NB, 8, sample and coefficient width (2..16)
DRAIN_CYC, 16, cycles waited after last sample before END_SIM (>=1)
LFSR_SEED, 16'hACE1, 16-bit LFSR reset/start value (nonzero)
H0_VAL..H6_VAL, 0, constant coefficient values driven on H0..H6

Ports:
CLK  in  1  clock, rising edge
RST_n  in  1  synchronous reset, active-low
START  in  1  start request, sampled only in IDLE
MODE  in  2  pattern: 0 ramp, 1 impulse, 2 LFSR, 3 alternating extremes
GAP  in  4  idle cycles between consecutive valid samples
NSAMP  in  16  number of samples to emit
DOUT  out  NB  sample, signed two's complement, registered
VOUT  out  1  sample valid, one cycle per sample, registered
H0..H6  out  NB each  coefficients = H0_VAL..H6_VAL
END_SIM  out  1  end-of-stream flag, sticky until reset

Behaviour:
- One clock CLK; RST_n is synchronous and active-low. While RST_n=0 at an edge: state=IDLE, DOUT=0, VOUT=0, END_SIM=0, counters=0, LFSR=LFSR_SEED. H0..H6 are constants and unaffected by reset.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on START=1, latch MODE, GAP and NSAMP.
  - NSAMP!=0 -> RUN.
  - NSAMP=0 -> DRAIN directly; no VOUT is emitted.
- RUN timing:
  - First VOUT=1 appears on the edge after START is sampled.
  - Each valid is followed by exactly GAP cycles of VOUT=0. GAP=0 gives back-to-back samples.
  - DOUT holds its last value while VOUT=0.
- RUN exit: after the NSAMP-th valid -> DRAIN. VOUT=0 from the next edge.
- DRAIN: count DRAIN_CYC cycles, then DONE. END_SIM=1 exactly DRAIN_CYC+1 edges after the last valid edge.
- DONE: END_SIM held at 1. Only reset leaves DONE.
- START outside IDLE is ignored. MODE, GAP and NSAMP changes after latching are ignored.
- Reset asserted in any state aborts immediately to IDLE with the reset values above. A partially emitted stream is not resumed.
- Pattern k = sample index, 0-based.
  - Ramp: DOUT = k mod 2^NB, wrapping, e.g. NB=8 gives ...,127,-128,...
  - Impulse: k=0 gives 2^(NB-1)-1; all other samples 0.
  - LFSR: 16-bit Fibonacci, next = {l[14:0], l[15]^l[13]^l[12]^l[10]}. DOUT = l[NB-1:0]. First sample uses the seed. The LFSR advances once per emitted sample only, and reloads to LFSR_SEED on START.
  - Alternating: even k gives +max (2^(NB-1)-1); odd k gives -max-1 (-2^(NB-1)).
- The sample counter is 16 bits, so NSAMP=65535 must complete without overflow.

Optional Feature:
Macro SRC_CHECKSUM_EN.
- Defined: adds output CHECKSUM (16 bits, registered, reset 0). On each VOUT=1 cycle, CHECKSUM += sign-extended DOUT, mod 2^16. It is cleared on START acceptance and frozen in DRAIN/DONE.
- Undefined: port and logic are absent; everything else is identical.

Test Plan:
- NB=8, MODE=0, GAP=0, NSAMP=4 -> VOUT high on 4 consecutive cycles starting 1 cycle after START, DOUT=0,1,2,3. END_SIM rises 17 edges after the last valid (DRAIN_CYC=16).
- MODE=2, GAP=2, NSAMP=3 -> DOUT=0xE1, 0xC3, then the next LFSR value. VOUT pattern is 1,0,0,1,0,0,1.
- MODE=1, NSAMP=3, then MODE=3, NSAMP=3 after reset -> impulse stream 127,0,0; alternating stream 127,-128,127.
- NSAMP=0 with START -> no VOUT; END_SIM=1 after DRAIN_CYC+1 edges. START pulses during RUN and DONE have no effect.
- Reset mid-RUN after 2 of 10 samples, then restart with NSAMP=2, ramp -> all outputs 0 during reset; new stream is 0,1 and restarts at index 0.
- SRC_CHECKSUM_EN defined, ramp, NSAMP=130, NB=8 -> CHECKSUM = sum of 0..127 plus -128,-127 = 8128-255 = 7873 (16'h1EC1).

Source files
------------

// File: rtl/fir_sample_source_if.sv
// Sample-stream bus between fir_sample_source and the FIR input: DOUT/VOUT, H0..H6, END_SIM.
// CHECKSUM is present only when SRC_CHECKSUM_EN is defined.
interface fir_sample_source_if #(
  parameter int unsigned NB = 8
);

  logic [NB-1:0] DOUT;
  logic          VOUT;
  logic [NB-1:0] H0;
  logic [NB-1:0] H1;
  logic [NB-1:0] H2;
  logic [NB-1:0] H3;
  logic [NB-1:0] H4;
  logic [NB-1:0] H5;
  logic [NB-1:0] H6;
  logic          END_SIM;
`ifdef SRC_CHECKSUM_EN
  logic [15:0]   CHECKSUM;
`endif

`ifdef SRC_CHECKSUM_EN
  modport master (
    output DOUT, VOUT, H0, H1, H2, H3, H4, H5, H6, END_SIM, CHECKSUM
  );

  modport slave (
    input DOUT, VOUT, H0, H1, H2, H3, H4, H5, H6, END_SIM, CHECKSUM
  );
`else
  modport master (
    output DOUT, VOUT, H0, H1, H2, H3, H4, H5, H6, END_SIM
  );

  modport slave (
    input DOUT, VOUT, H0, H1, H2, H3, H4, H5, H6, END_SIM
  );
`endif

endinterface

// File: rtl/fir_sample_source.sv
// Programmable FIR stimulus source: ramp/impulse/LFSR/alternating samples with idle gaps, then END_SIM.
// Optional macro SRC_CHECKSUM_EN adds a 16-bit running sum of emitted samples on CHECKSUM.
module fir_sample_source #(
  parameter int unsigned NB        = 8,
  parameter int unsigned DRAIN_CYC = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          H0_VAL    = 0,
  parameter int          H1_VAL    = 0,
  parameter int          H2_VAL    = 0,
  parameter int          H3_VAL    = 0,
  parameter int          H4_VAL    = 0,
  parameter int          H5_VAL    = 0,
  parameter int          H6_VAL    = 0
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 START,
  input  logic [1:0]           MODE,
  input  logic [3:0]           GAP,
  input  logic [15:0]          NSAMP,
  fir_sample_source_if.master  bus
);

  localparam int unsigned CW  = 16;
  localparam int unsigned GW  = 4;
  localparam int unsigned DCW = $clog2(DRAIN_CYC + 1);

  localparam logic [NB-1:0] SMAX = {1'b0, {(NB-1){1'b1}}};
  localparam logic [NB-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [1:0]      mode_q;
  logic [GW-1:0]   gap_q;
  logic [CW-1:0]   nsamp_q;
  logic [CW-1:0]   k_q;
  logic [GW-1:0]   gap_cnt_q;
  logic [DCW-1:0]  drain_cnt_q;
  logic [15:0]     lfsr_q;
  logic [NB-1:0]   dout_q;
  logic            vout_q;
  logic            end_sim_q;
`ifdef SRC_CHECKSUM_EN
  logic [15:0]     checksum_q;
`endif

  logic [NB-1:0]   sample_c;
  logic [15:0]     lfsr_next_c;
  logic            last_c;

  // Pattern value for the current sample index k_q
  always_comb begin
    sample_c = '0;
    unique case (mode_q)
      2'd0:    sample_c = k_q[NB-1:0];
      2'd1:    sample_c = (k_q == '0) ? SMAX : '0;
      2'd2:    sample_c = lfsr_q[NB-1:0];
      default: sample_c = k_q[0] ? SMIN : SMAX;
    endcase
  end

  assign lfsr_next_c = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign last_c      = (k_q == (nsamp_q - CW'(1)));

  // Sequencer: latch request, pace samples by GAP, drain, then hold END_SIM
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      gap_q       <= '0;
      nsamp_q     <= '0;
      k_q         <= '0;
      gap_cnt_q   <= '0;
      drain_cnt_q <= '0;
      lfsr_q      <= LFSR_SEED;
      dout_q      <= '0;
      vout_q      <= 1'b0;
      end_sim_q   <= 1'b0;
`ifdef SRC_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      vout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (START) begin
            mode_q      <= MODE;
            gap_q       <= GAP;
            nsamp_q     <= NSAMP;
            k_q         <= '0;
            gap_cnt_q   <= '0;
            drain_cnt_q <= '0;
            lfsr_q      <= LFSR_SEED;
`ifdef SRC_CHECKSUM_EN
            checksum_q  <= '0;
`endif
            state_q     <= (NSAMP == '0) ? DRAIN : RUN;
          end
        end

        RUN: begin
          if (gap_cnt_q == '0) begin
            vout_q    <= 1'b1;
            dout_q    <= sample_c;
            k_q       <= k_q + CW'(1);
            gap_cnt_q <= gap_q;
            lfsr_q    <= lfsr_next_c;
`ifdef SRC_CHECKSUM_EN
            checksum_q <= checksum_q + 16'($signed(sample_c));
`endif
            if (last_c) begin
              state_q <= DRAIN;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q - GW'(1);
          end
        end

        // Entered on the last-valid edge; fires DRAIN_CYC+1 edges later
        DRAIN: begin
          if (drain_cnt_q == DCW'(DRAIN_CYC)) begin
            end_sim_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            drain_cnt_q <= drain_cnt_q + DCW'(1);
          end
        end

        DONE: begin
          end_sim_q <= 1'b1;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.DOUT    = dout_q;
  assign bus.VOUT    = vout_q;
  assign bus.END_SIM = end_sim_q;
`ifdef SRC_CHECKSUM_EN
  assign bus.CHECKSUM = checksum_q;
`endif

  // Coefficients are build-time constants, independent of reset
  assign bus.H0 = NB'(H0_VAL);
  assign bus.H1 = NB'(H1_VAL);
  assign bus.H2 = NB'(H2_VAL);
  assign bus.H3 = NB'(H3_VAL);
  assign bus.H4 = NB'(H4_VAL);
  assign bus.H5 = NB'(H5_VAL);
  assign bus.H6 = NB'(H6_VAL);

endmodule
